// File: rtl/cic_decim_param.sv
// cic_decim_param: parametrised CIC decimator for a 1-bit sigma-delta bitstream.
// ORDER integrators run at the input rate and ORDER combs run at the decimated rate.
// The power-of-two decimation ratio 2^dec_log2 is selected at runtime.
// A warm-up period suppresses the first ORDER decimated results after a reset or
// a rate change.
// Optional macro CIC_NORM_EN: when defined, the output is left-shifted so that
// full scale is 2^(ACC_W-1) for every ratio.
module cic_decim_param #(
  parameter int ORDER     = 3,
  parameter int LOG2_RMAX = 8,
  parameter int ACC_W     = ORDER*LOG2_RMAX+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic [3:0]       dec_log2,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  output logic             rate_busy
);

  localparam int WU_W = $clog2(ORDER+1);

  // Legal ratio range is 1..LOG2_RMAX; anything outside is pulled to the nearest end.
  function automatic logic [3:0] clamp_dec(input logic [3:0] d);
    if (d == 4'd0)                return 4'd1;
    else if (d > 4'(LOG2_RMAX))   return 4'(LOG2_RMAX);
    else                          return d;
  endfunction

`ifdef CIC_NORM_EN
  // Scale the result up so that full scale sits at 2^(ACC_W-1) whatever the ratio.
  function automatic logic [ACC_W-1:0] norm_out(input logic [ACC_W-1:0] v,
                                                input logic [3:0]       d);
    return v << (ORDER * (LOG2_RMAX - int'(d)));
  endfunction
`endif

  logic [3:0]           dec_r_q;
  logic [LOG2_RMAX-1:0] cnt_q;
  logic [WU_W-1:0]      wu_q;
  logic                 vld_p1_q;
  logic                 out_valid_q;
  logic                 rate_busy_q;
  logic [ACC_W-1:0]     integ_q [ORDER];
  logic [ACC_W-1:0]     integ_d [ORDER];
  logic [ACC_W-1:0]     comb_q  [ORDER];
  logic [ACC_W-1:0]     comb_in [ORDER];
  logic [ACC_W-1:0]     comb_out;
  logic [ACC_W-1:0]     samp_p1_q;
  logic [ACC_W-1:0]     out_q;
  logic [ACC_W-1:0]     out_d;

  logic [3:0] dec_in;
  logic       rate_chg;
  logic       last_cnt;
  logic       tick;
  logic       emit;

  assign dec_in   = clamp_dec(dec_log2);
  assign rate_chg = (dec_in != dec_r_q);
  assign last_cnt = (cnt_q == LOG2_RMAX'((32'd1 << dec_r_q) - 32'd1));
  // A rate change on the same edge as a tick wins: the tick is dropped.
  assign tick     = in_valid && !rate_chg && last_cnt;
  assign emit     = vld_p1_q && !rate_chg && (wu_q == WU_W'(ORDER));

  // Integrator cascade: stage 1 accumulates the bit, stage k accumulates stage k-1's new value.
  always_comb begin : integ_chain
    logic [ACC_W-1:0] acc;
    acc = {{(ACC_W-1){1'b0}}, in};
    for (int k = 0; k < ORDER; k++) begin
      acc        = integ_q[k] + acc;
      integ_d[k] = acc;
    end
  end

  // Comb cascade: each stage subtracts its own previous decimated input.
  always_comb begin : comb_chain
    logic [ACC_W-1:0] v;
    v = samp_p1_q;
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = v;
      v          = v - comb_q[k];
    end
    comb_out = v;
  end

`ifdef CIC_NORM_EN
  assign out_d = norm_out(comb_out, dec_r_q);
`else
  assign out_d = comb_out;
`endif

  // Control: ratio register, decimation counter, warm-up count and status strobes.
  always_ff @(posedge clk) begin
    if (reset || rate_chg) begin
      dec_r_q     <= dec_in;
      cnt_q       <= '0;
      wu_q        <= '0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      rate_busy_q <= 1'b1;
    end else begin
      vld_p1_q    <= tick;
      out_valid_q <= emit;
      if (in_valid)
        cnt_q <= tick ? '0 : cnt_q + LOG2_RMAX'(1);
      if (vld_p1_q && (wu_q != WU_W'(ORDER)))
        wu_q <= wu_q + WU_W'(1);
      if (emit)
        rate_busy_q <= 1'b0;
    end
  end

  // Datapath: integrators at input rate, tick sample (p0->p1), comb delays at tick rate.
  always_ff @(posedge clk) begin
    if (reset || rate_chg) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
      end
      samp_p1_q <= '0;
    end else begin
      if (in_valid)
        for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
      if (tick)
        samp_p1_q <= integ_d[ORDER-1];
      if (vld_p1_q)
        for (int k = 0; k < ORDER; k++) comb_q[k] <= comb_in[k];
    end
  end

  // Output register (p1->p2): loads only on post-warm-up results, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset)
      out_q <= '0;
    else if (emit)
      out_q <= out_d;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign rate_busy = rate_busy_q;

endmodule

// File: tb/tb_cic_decim_param.sv
// Testbench for cic_decim_param: directed stimulus, an impulse-response model of
// the filter, and literal expectations for each scenario.
module tb_cic_decim_param;

  localparam int ORDER     = 3;
  localparam int LOG2_RMAX = 8;
  localparam int ACC_W     = ORDER*LOG2_RMAX+1;
  localparam int HMAX      = ORDER*((1 << LOG2_RMAX) - 1) + 1;
`ifdef CIC_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       dec_log2 = 4'd8;
  logic [ACC_W-1:0] out;
  logic             out_valid;
  logic             rate_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cic_decim_param #(.ORDER(ORDER), .LOG2_RMAX(LOG2_RMAX)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .dec_log2(dec_log2),
    .out(out), .out_valid(out_valid), .rate_busy(rate_busy)
  );

  // ---------------- behavioural model ----------------
  // The filter starts from zero state after every reset/rate change, so each
  // decimated result is the input history convolved with the CIC impulse
  // response (ORDER-fold convolution of a length-R boxcar), modulo 2^ACC_W.
  bit               started = 1'b0;
  int               m_dec, m_cnt, m_nt;
  bit               m_pend;
  logic [ACC_W-1:0] m_pend_val;
  logic [ACC_W-1:0] exp_out = '0;
  bit               exp_vld = 1'b0, exp_busy = 1'b1;
  bit               hist[$];
  longint           h[HMAX];
  int               h_len;

  function automatic int clampd(input logic [3:0] d);
    if (d == 0) return 1;
    if (int'(d) > LOG2_RMAX) return LOG2_RMAX;
    return int'(d);
  endfunction

  function automatic void build_h(input int d);
    longint t[HMAX];
    int r;
    r = 1 << d;
    for (int i = 0; i < HMAX; i++) h[i] = 0;
    h[0] = 1;
    h_len = 1;
    repeat (ORDER) begin
      for (int i = 0; i < HMAX; i++) t[i] = 0;
      for (int i = 0; i < h_len; i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      h_len += r - 1;
      for (int i = 0; i < HMAX; i++) h[i] = t[i];
    end
  endfunction

  function automatic logic [ACC_W-1:0] conv_now();
    longint s;
    logic [ACC_W-1:0] v;
    s = 0;
    for (int k = 0; k < h_len && k < hist.size(); k++)
      if (hist[hist.size()-1-k]) s += h[k];
    v = ACC_W'(s);
    if (NORM) v = v << (ORDER * (LOG2_RMAX - m_dec));
    return v;
  endfunction

  function automatic void model_restart(input int d);
    m_dec = d;
    build_h(d);
    hist.delete();
    m_cnt = 0; m_nt = 0; m_pend = 1'b0;
    exp_vld = 1'b0; exp_busy = 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      model_restart(clampd(dec_log2));
      exp_out = '0;
    end else if (started) begin
      if (clampd(dec_log2) != m_dec) begin
        model_restart(clampd(dec_log2));
      end else begin
        exp_vld = 1'b0;
        if (m_pend) begin
          m_pend = 1'b0;
          if (m_nt > ORDER) begin
            exp_out = m_pend_val; exp_vld = 1'b1; exp_busy = 1'b0;
          end
        end
        if (in_valid) begin
          hist.push_back(in);
          if (hist.size() > HMAX) void'(hist.pop_front());
          m_cnt++;
          if (m_cnt == (1 << m_dec)) begin
            m_cnt = 0; m_nt++; m_pend = 1'b1; m_pend_val = conv_now();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      n_tests++;
      if (out_valid !== exp_vld) begin
        n_fail++;
        $display("FAIL model_out_valid t=%0t got %b want %b", $time, out_valid, exp_vld);
      end
      n_tests++;
      if (rate_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL model_rate_busy t=%0t got %b want %b", $time, rate_busy, exp_busy);
      end
      n_tests++;
      if (out !== exp_out) begin
        n_fail++;
        $display("FAIL model_out t=%0t got %0d want %0d", $time, out, exp_out);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int pat  = 0;   // 0: all ones, 1: all zeros, 2: alternating
  int vpat = 0;   // 0: in_valid always, 1: one cycle in three
  int phase = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    phase++;
    case (pat)
      0:       in = 1'b1;
      1:       in = 1'b0;
      default: in = phase[0];
    endcase
    in_valid = (vpat == 0) ? 1'b1 : (phase % 3 == 0);
  endtask

  task automatic do_reset(input logic [3:0] d);
    reset = 1'b1;
    dec_log2 = d;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout got no out_valid want one within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    int c;
    // Reset state
    pat = 0; vpat = 0;
    do_reset(4'd8);
    chk("reset_out", out, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rate_busy", rate_busy, 1);

    // R=256, all ones: full scale 2^24
    wait_pulse("r256_first", 1100, c);
    chk("r256_first_latency", c, 1025);
    chk("r256_first_out", out, 16777216);
    chk("r256_busy_clear", rate_busy, 0);
    wait_pulse("r256_second", 300, c);
    chk("r256_period", c, 256);
    chk("r256_second_out", out, 16777216);

    // R=256, all zeros
    pat = 1;
    do_reset(4'd8);
    wait_pulse("zero_first", 1100, c);
    chk("zero_latency", c, 1025);
    chk("zero_out", out, 0);

    // R=4, alternating input
    pat = 2;
    do_reset(4'd2);
    wait_pulse("alt_first", 40, c);
    chk("alt_latency", c, 17);
    chk("alt_out", out, NORM ? 8388608 : 32);
    wait_pulse("alt_second", 10, c);
    chk("alt_period", c, 4);
    chk("alt_out2", out, NORM ? 8388608 : 32);

    // R=16, in_valid one cycle in three
    pat = 0; vpat = 1;
    do_reset(4'd4);
    wait_pulse("sparse_first", 300, c);
    wait_pulse("sparse_second", 100, c);
    chk("sparse_period", c, 48);
    chk("sparse_out", out, NORM ? 16777216 : 4096);

    // dec_log2=0 clamps to 1; moving to 1 is then not a rate change
    vpat = 0;
    do_reset(4'd0);
    wait_pulse("clamp_first", 30, c);
    chk("clamp_latency", c, 9);
    chk("clamp_out", out, NORM ? 16777216 : 8);
    dec_log2 = 4'd1;
    wait_pulse("clamp_second", 10, c);
    chk("clamp_no_resync", c, 2);

    // Rate change 8 -> 3 mid-frame
    do_reset(4'd8);
    wait_pulse("chg_settle", 1100, c);
    repeat (100) step();
    dec_log2 = 4'd3;
    step();
    chk("chg_busy", rate_busy, 1);
    chk("chg_no_valid", out_valid, 0);
    chk("chg_out_held", out, 16777216);
    wait_pulse("chg_first", 60, c);
    chk("chg_latency", c, 33);
    chk("chg_out", out, NORM ? 16777216 : 512);
    wait_pulse("chg_second", 20, c);
    chk("chg_period", c, 8);

    // One-cycle reset mid-frame
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midrst_out", out, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", rate_busy, 1);
    reset = 1'b0;
    wait_pulse("midrst_first", 60, c);
    chk("midrst_latency", c, 33);
    chk("midrst_out_after", out, NORM ? 16777216 : 512);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
